// File: rtl/conv_phase_sequencer_pkg.sv
// Shared definitions for the conv phase sequencer: phase codes (also used by the
// memory control unit), FSM state encoding and a width helper.
package conv_seq_pkg;

    localparam logic [1:0] PH_LOAD = 2'b00;
    localparam logic [1:0] PH_PROC = 2'b01;
    localparam logic [1:0] PH_OUT  = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_XFER,
        ST_LOAD_CHB,
        ST_PROC,
        ST_OUT_XFER,
        ST_OUT_CHB,
        ST_DONE
    } seq_state_e;

    // Bits needed to hold values 0..v-1; never less than 1.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/conv_phase_sequencer_chblk.sv
// Column-change pulse: CHBLK_HOLD cycles high, then one low guard cycle that
// raises o_fin so the caller can leave its *_CHB state.
module chblk_pulse_gen
    import conv_seq_pkg::*;
#(
    parameter int CHBLK_HOLD = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    output logic o_chblk,
    output logic o_busy,
    output logic o_fin
);

    localparam int CW = clog2(CHBLK_HOLD + 1);
    localparam logic [CW-1:0] HOLD_V = CW'(CHBLK_HOLD);

    logic          r_busy;
    logic [CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start && !r_busy) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
        end else if (r_busy) begin
            if (r_cnt == HOLD_V) r_busy <= 1'b0;
            else                 r_cnt  <= r_cnt + CW'(1);
        end
    end

    assign o_chblk = r_busy && (r_cnt < HOLD_V);
    assign o_fin   = r_busy && (r_cnt == HOLD_V);
    assign o_busy  = r_busy;

endmodule

// File: rtl/conv_phase_sequencer.sv
// Row-band phase sequencer (LOAD/PROC/OUT + chblk) for the conv memory control unit.
// Optional PROC watchdog with sticky o_err: define CONV_SEQ_PROC_TIMEOUT_EN.
module conv_phase_sequencer
    import conv_seq_pkg::*;
#(
    parameter int N          = 2,
    parameter int IMG_W      = 8,
    parameter int COL_LEN    = 16,
    parameter int CHBLK_HOLD = 2
`ifdef CONV_SEQ_PROC_TIMEOUT_EN
    ,
    parameter int PROC_TMO   = 1024
`endif
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_start,
    input  logic                       i_in_valid,
    output logic                       o_in_ready,
    output logic                       o_wr_en,
    output logic [clog2(COL_LEN)-1:0]  o_addr,
    input  logic                       i_proc_done,
    output logic                       o_out_valid,
    input  logic                       i_out_ready,
    output logic                       o_sop,
    output logic                       o_eop,
    output logic                       o_chblk,
    output logic                       o_busy,
`ifdef CONV_SEQ_PROC_TIMEOUT_EN
    output logic                       o_err,
`endif
    output logic                       o_done
);

    localparam int AW  = clog2(COL_LEN);
    localparam int CCW = clog2(IMG_W + 1);
    localparam logic [AW-1:0]  ADDR_LAST  = AW'(COL_LEN - 1);
    localparam logic [CCW-1:0] PRIME_COLS = CCW'(N + 1);
    localparam logic [CCW-1:0] IMG_COLS   = CCW'(IMG_W);

    seq_state_e     r_state, w_next;
    logic [AW-1:0]  r_addr;
    logic [CCW-1:0] r_col_cnt;
    logic           r_prime;

    logic           w_in_hs, w_out_hs, w_last, w_chb_start;
    logic           w_pg_start, w_pg_busy, w_pg_fin;
    logic [CCW-1:0] w_col_next;
    logic           w_more_prime;
    logic           w_tmo_hit;

    assign w_in_hs      = (r_state == ST_LOAD_XFER) && i_in_valid;
    assign w_out_hs     = (r_state == ST_OUT_XFER) && i_out_ready;
    assign w_last       = (r_addr == ADDR_LAST);
    assign w_chb_start  = (w_in_hs || w_out_hs) && w_last;
    assign w_pg_start   = w_chb_start && !w_pg_busy;
    assign w_col_next   = r_col_cnt + CCW'(1);
    // Keep loading until the first N+1 columns are resident.
    assign w_more_prime = r_prime && (w_col_next < PRIME_COLS);

    chblk_pulse_gen #(.CHBLK_HOLD(CHBLK_HOLD)) u_chblk (
        .clk     (clk),
        .rst     (rst),
        .i_start (w_pg_start),
        .o_chblk (o_chblk),
        .o_busy  (w_pg_busy),
        .o_fin   (w_pg_fin)
    );

`ifdef CONV_SEQ_PROC_TIMEOUT_EN
    localparam int TW = clog2(PROC_TMO + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(PROC_TMO - 1);
    logic [TW-1:0] r_tmo;
    logic          r_err;

    assign w_tmo_hit = (r_state == ST_PROC) && !i_proc_done && (r_tmo == TMO_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmo <= '0;
            r_err <= 1'b0;
        end else begin
            r_tmo <= (r_state == ST_PROC) ? r_tmo + TW'(1) : '0;
            if (r_state == ST_IDLE && i_start) r_err <= 1'b0;
            else if (w_tmo_hit)                r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:      if (i_start) w_next = ST_LOAD_XFER;
            ST_LOAD_XFER: if (w_in_hs && w_last) w_next = ST_LOAD_CHB;
            ST_LOAD_CHB:  if (w_pg_fin) w_next = w_more_prime ? ST_LOAD_XFER : ST_PROC;
            ST_PROC: begin
                if (i_proc_done)    w_next = ST_OUT_XFER;
                else if (w_tmo_hit) w_next = ST_DONE;
            end
            ST_OUT_XFER:  if (w_out_hs && w_last) w_next = ST_OUT_CHB;
            ST_OUT_CHB:   if (w_pg_fin) w_next = (r_col_cnt == IMG_COLS) ? ST_DONE : ST_LOAD_XFER;
            ST_DONE:      w_next = ST_IDLE;
            default:      w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        o_sop       = 1'b0;
        o_eop       = 1'b0;
        o_done      = 1'b0;
        o_busy      = (r_state != ST_IDLE);
        case (r_state)
            ST_LOAD_XFER: o_in_ready = 1'b1;
            ST_PROC:      {o_eop, o_sop} = PH_PROC;
            ST_OUT_XFER: begin
                o_out_valid    = 1'b1;
                {o_eop, o_sop} = PH_OUT;
            end
            ST_OUT_CHB:   {o_eop, o_sop} = PH_OUT;
            ST_DONE:      o_done = 1'b1;
            default:      {o_eop, o_sop} = PH_LOAD;
        endcase
    end

    assign o_wr_en = o_in_ready & i_in_valid;
    assign o_addr  = r_addr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_addr    <= '0;
            r_col_cnt <= '0;
            r_prime   <= 1'b0;
        end else begin
            if (w_in_hs || w_out_hs)
                r_addr <= w_last ? '0 : r_addr + AW'(1);
            if (r_state == ST_IDLE && i_start) begin
                r_col_cnt <= '0;
                r_prime   <= 1'b1;
            end else if (r_state == ST_LOAD_CHB && w_pg_fin) begin
                r_col_cnt <= w_col_next;
                if (!w_more_prime) r_prime <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_conv_phase_sequencer.sv
// Directed bench for conv_phase_sequencer (N=2, IMG_W=5, COL_LEN=4, CHBLK_HOLD=2).
// Timeout band runs only when CONV_SEQ_PROC_TIMEOUT_EN is defined.
module tb_conv_phase_sequencer;

    localparam int N = 2, IMG_W = 5, COL_LEN = 4, HOLD = 2;

    logic       clk = 1'b0, rst = 1'b0;
    logic       i_start = 1'b0, i_in_valid = 1'b0, i_proc_done = 1'b0, i_out_ready = 1'b0;
    logic       o_in_ready, o_wr_en, o_out_valid, o_sop, o_eop, o_chblk, o_busy, o_done;
    logic [1:0] o_addr;
`ifdef CONV_SEQ_PROC_TIMEOUT_EN
    logic       o_err;
`endif

    int checks = 0, failures = 0;
    int n_in, n_out, n_chb, n_done, proc_max, exp_addr, aborted;
    logic [31:0] ph_log, chb_log;
    logic err_at_done, err_after_start;

    always #5 clk = ~clk;

    conv_phase_sequencer #(
        .N(N), .IMG_W(IMG_W), .COL_LEN(COL_LEN), .CHBLK_HOLD(HOLD)
`ifdef CONV_SEQ_PROC_TIMEOUT_EN
        , .PROC_TMO(8)
`endif
    ) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_in_valid(i_in_valid),
        .o_in_ready(o_in_ready), .o_wr_en(o_wr_en), .o_addr(o_addr),
        .i_proc_done(i_proc_done), .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
        .o_sop(o_sop), .o_eop(o_eop), .o_chblk(o_chblk), .o_busy(o_busy),
`ifdef CONV_SEQ_PROC_TIMEOUT_EN
        .o_err(o_err),
`endif
        .o_done(o_done)
    );

    task automatic chk(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint outs_vec();
        return longint'({o_in_ready, o_wr_en, o_addr, o_out_valid, o_sop, o_eop, o_chblk, o_busy, o_done});
    endfunction

    // vmode: 0 valid always, 1 every other cycle; rmode: 0 ready always, 1 one in three;
    // pdmode: 0 proc_done on 3rd PROC cycle, 1 never; smode 1: stray starts in OUT and DONE;
    // abort_at: reset during PROC of that output column (0 = none).
    task automatic run_band(input int vmode, input int rmode, input int pdmode,
                            input int smode, input int abort_at);
        int proc_cyc = 0, proc_entries = 0, run = 0;
        logic [1:0] ph, prev_ph = 2'b00;
        logic prev_chb = 1'b0, seen_out = 1'b0, finished = 1'b0;
        n_in = 0; n_out = 0; n_chb = 0; n_done = 0; proc_max = 0; exp_addr = 0;
        ph_log = '0; chb_log = '0; aborted = 0;
        err_at_done = 1'b0; err_after_start = 1'b1;
        @(negedge clk);
        i_start = 1'b1;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            i_in_valid  = (vmode == 0) ? 1'b1 : (cyc % 2 == 0);
            i_out_ready = (rmode == 0) ? 1'b1 : (cyc % 3 == 0);
            if (o_sop && !o_eop) proc_cyc++; else proc_cyc = 0;
            if (proc_cyc == 1) proc_entries++;
            if (proc_cyc > proc_max) proc_max = proc_cyc;
            i_proc_done = (pdmode == 0) && (proc_cyc >= 3);
            i_start = 1'b0;
            if (smode == 1 && o_out_valid && !seen_out) begin i_start = 1'b1; seen_out = 1'b1; end
            if (smode == 1 && o_done) i_start = 1'b1;
            if (abort_at != 0 && proc_entries == abort_at && proc_cyc == 2) begin
                rst = 1'b0;
                #1;
                chk("abort_outputs_zero", outs_vec(), 0);
                i_proc_done = 1'b0; i_in_valid = 1'b0; i_out_ready = 1'b0;
                aborted = 1;
                return;
            end
            #1;
`ifdef CONV_SEQ_PROC_TIMEOUT_EN
            if (cyc == 0) err_after_start = o_err;
            if (o_done) err_at_done = o_err;
`endif
            ph = {o_eop, o_sop};
            if (o_busy) chk("addr", o_addr, exp_addr);
            chk("wr_en", o_wr_en, o_in_ready & i_in_valid);
            chk("rdy_vld_excl", o_in_ready & o_out_valid, 0);
            if (o_wr_en) begin n_in++; exp_addr = (exp_addr + 1) % COL_LEN; end
            if (o_out_valid && i_out_ready) begin n_out++; exp_addr = (exp_addr + 1) % COL_LEN; end
            if (prev_chb) chk("phase_stable_chblk", ph, prev_ph);
            if (o_chblk) begin
                if (!prev_chb) begin n_chb++; chb_log = (chb_log << 2) | 32'(ph); end
                run++;
            end else if (prev_chb) begin
                chk("chblk_len", run, HOLD);
                run = 0;
            end
            if (ph != prev_ph) ph_log = (ph_log << 2) | 32'(ph);
            if (o_done) n_done++;
            prev_ph = ph; prev_chb = o_chblk;
            if (n_done > 0 && !o_busy) begin finished = 1'b1; break; end
        end
        i_start = 1'b0;
        chk("band_completes", finished, 1);
    endtask

    task automatic check_full_band(input string tag);
        chk({tag, "_in_words"}, n_in, 20);
        chk({tag, "_out_words"}, n_out, 12);
        chk({tag, "_chblk_pulses"}, n_chb, 8);
        chk({tag, "_done_cycles"}, n_done, 1);
        chk({tag, "_phase_seq"}, ph_log, 32'h0001_8618);
        chk({tag, "_chblk_phases"}, chb_log, 32'h0000_0222);
        chk({tag, "_proc_len"}, proc_max, 3);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_outputs", outs_vec(), 0);
`ifdef CONV_SEQ_PROC_TIMEOUT_EN
        chk("reset_err", o_err, 0);
`endif
        rst = 1'b1;
        @(negedge clk);
        i_proc_done = 1'b1;
        @(negedge clk);
        chk("proc_done_ignored_idle", o_busy, 0);
        i_proc_done = 1'b0;

        run_band(0, 0, 0, 0, 0);
        check_full_band("ready");

        run_band(1, 1, 0, 0, 0);
        check_full_band("throttled");

        run_band(0, 0, 0, 1, 0);
        check_full_band("stray_start");
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("idle_after_stray_start", o_busy, 0);
        end

        run_band(0, 0, 0, 0, 2);
        chk("abort_taken", aborted, 1);
        chk("abort_no_done", n_done, 0);
        @(negedge clk);
        chk("abort_held_idle", outs_vec(), 0);
        rst = 1'b1;
        run_band(0, 0, 0, 0, 0);
        check_full_band("after_abort");

`ifdef CONV_SEQ_PROC_TIMEOUT_EN
        run_band(0, 0, 1, 0, 0);
        chk("tmo_proc_len", proc_max, 8);
        chk("tmo_err_at_done", err_at_done, 1);
        chk("tmo_done_cycles", n_done, 1);
        chk("tmo_in_words", n_in, 12);
        chk("tmo_out_words", n_out, 0);
        chk("tmo_chblk_pulses", n_chb, 3);
        @(negedge clk);
        chk("tmo_err_sticky", o_err, 1);
        run_band(0, 0, 0, 0, 0);
        chk("tmo_err_cleared", err_after_start, 0);
        check_full_band("after_tmo");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
